// File: rtl/config_loader.sv
// config_loader
// Upstream write sequencer for the per-core configuration memory. Takes a
// stream of header + payload flits and turns every payload flit into one
// registered, single-cycle write on the memory's config-mode port.
//
// Header flit layout: [31:28] target index T, [27:12] base address (low
// NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH bits used), [11:0] payload count N.
//
// Ports:
//   clk_i                  clock
//   rst_i                  synchronous active-high reset
//   flit_data_i            header or payload flit
//   flit_valid_i           flit_data_i is valid
//   flit_ready_o           block accepts a flit this cycle
//   config_data_o          write data (holds when ce_o = 0)
//   config_write_enable_o  one-hot target write strobe
//   config_addr_o          write address (holds when ce_o = 0)
//   ce_o                   memory clock enable, OR of the write strobes
//   busy_o                 packet in progress (state != IDLE)
//   done_o                 one-cycle pulse when a packet completes normally
//   err_o                  sticky error, cleared by the next header
//   state_o                FSM state for debug (0 IDLE, 1 DATA, 2 DRAIN, 3 DONE)
//
// Optional feature: define CFG_LOADER_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYCLES consecutive cycles without a handshake in DATA or DRAIN.

module config_loader #(
    parameter int DSIZE                   = 16,
    parameter int NURN_CNT_BIT_WIDTH      = 8,
    parameter int AXON_CNT_BIT_WIDTH      = 8,
    parameter int CONFIG_PARAMETER_NUMBER = 9,
    parameter int TIMEOUT_CYCLES          = 255
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic [DSIZE*2-1:0]                               flit_data_i,
    input  logic                                             flit_valid_i,
    output logic                                             flit_ready_o,
    output logic [DSIZE*2-1:0]                               config_data_o,
    output logic [CONFIG_PARAMETER_NUMBER-1:0]               config_write_enable_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] config_addr_o,
    output logic                                             ce_o,
    output logic                                             busy_o,
    output logic                                             done_o,
    output logic                                             err_o,
    output logic [1:0]                                       state_o
);

    localparam int FW = DSIZE * 2;
    localparam int AW = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic   [AW-1:0]                      base_q;
    logic   [3:0]                         tgt_q;
    logic   [11:0]                        cnt_q;
    logic   [11:0]                        idx_q;
    logic   [FW-1:0]                      data_q;
    logic   [AW-1:0]                      addr_q;
    logic   [CONFIG_PARAMETER_NUMBER-1:0] we_q;
    logic                                 err_q;

    logic                                 hs;
    logic                                 last;
    logic                                 hdr_bad;
    logic   [3:0]                         hdr_tgt;
    logic   [11:0]                        hdr_cnt;
    logic   [AW-1:0]                      hdr_base;
    logic   [CONFIG_PARAMETER_NUMBER-1:0] we_onehot;
    logic                                 timeout;

    // Handshake: a flit moves when flit_valid_i && flit_ready_o at a rising
    // edge. Ready is high in IDLE, DATA and DRAIN, low in DONE and during
    // reset; it never depends on flit_valid_i.
    assign flit_ready_o = !rst_i && (state_q != DONE);
    assign hs           = flit_valid_i && flit_ready_o;

    assign hdr_tgt  = flit_data_i[31:28];
    assign hdr_base = flit_data_i[12 +: AW];
    assign hdr_cnt  = flit_data_i[11:0];
    assign hdr_bad  = ({28'd0, hdr_tgt} >= 32'(CONFIG_PARAMETER_NUMBER));
    assign last     = (idx_q == cnt_q - 12'd1);

`ifdef CFG_LOADER_TIMEOUT_EN
    logic [15:0] stall_q;

    assign timeout = ((state_q == DATA) || (state_q == DRAIN)) && !hs &&
                     (stall_q == 16'(TIMEOUT_CYCLES - 1));

    // Counts consecutive handshake-free cycles while a packet is open.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (((state_q == DATA) || (state_q == DRAIN)) && !hs && !timeout) begin
            stall_q <= stall_q + 16'd1;
        end else begin
            stall_q <= '0;
        end
    end
`else
    // Without the stall counter the block waits for payload indefinitely.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        we_onehot = '0;
        for (int i = 0; i < CONFIG_PARAMETER_NUMBER; i++) begin
            we_onehot[i] = (tgt_q == 4'(i));
        end
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (hdr_cnt == 12'd0) state_d = DONE;
                    else if (hdr_bad)     state_d = DRAIN;
                    else                  state_d = DATA;
                end
            end
            DATA, DRAIN: begin
                if (hs && last)   state_d = DONE;
                else if (timeout) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Strobes live for exactly one cycle; data and address hold.
            we_q    <= '0;
            if (state_q == IDLE && hs) begin
                base_q <= hdr_base;
                tgt_q  <= hdr_tgt;
                cnt_q  <= hdr_cnt;
                idx_q  <= '0;
                err_q  <= hdr_bad;
            end
            if ((state_q == DATA || state_q == DRAIN) && hs) begin
                idx_q <= last ? 12'd0 : idx_q + 12'd1;
            end
            if (state_q == DATA && hs) begin
                data_q <= flit_data_i;
                addr_q <= base_q + AW'(idx_q);  // wraps modulo 2^AW
                we_q   <= we_onehot;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign config_data_o         = data_q;
    assign config_addr_o         = addr_q;
    assign config_write_enable_o = we_q;
    assign ce_o                  = |we_q;
    assign busy_o                = (state_q != IDLE);
    assign done_o                = (state_q == DONE);
    assign err_o                 = err_q;
    assign state_o               = state_q;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader. Payload writes are pushed to an
// expected queue (with the cycle they must appear in) when driven; a negedge
// monitor pops and compares every write the DUT produces. Scenario tasks
// check control outputs inline.

module tb_config_loader;

    localparam int CPN = 9;
    localparam int AW  = 16;
    localparam int FW  = 32;
    localparam int W   = 32 + CPN + AW + FW;
`ifdef CFG_LOADER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [FW-1:0]  flit_data_i;
    logic           flit_valid_i;
    logic           flit_ready_o;
    logic [FW-1:0]  config_data_o;
    logic [CPN-1:0] config_write_enable_o;
    logic [AW-1:0]  config_addr_o;
    logic           ce_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;
    logic [1:0]     state_o;

    config_loader #(
        .DSIZE(16), .NURN_CNT_BIT_WIDTH(8), .AXON_CNT_BIT_WIDTH(8),
        .CONFIG_PARAMETER_NUMBER(CPN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .flit_data_i(flit_data_i), .flit_valid_i(flit_valid_i),
        .flit_ready_o(flit_ready_o), .config_data_o(config_data_o),
        .config_write_enable_o(config_write_enable_o),
        .config_addr_o(config_addr_o), .ce_o(ce_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   mon_e;
    logic [31:0]    mon_cyc;
    logic [CPN-1:0] mon_we;
    logic [AW-1:0]  mon_addr;
    logic [FW-1:0]  mon_data;
    bit             mon_due;

    always @(negedge clk_i) begin
        mon_due = (exp_q.size() > 0) && (int'(exp_q[0][W-1 -: 32]) <= cyc);
        if (mon_due || ce_o === 1'b1 || config_write_enable_o !== '0) begin
            n_checks++;
            if (!mon_due) begin
                $display("FAIL unexpected_write: got we=%b addr=%h data=%h at cycle %0d, required no write",
                         config_write_enable_o, config_addr_o, config_data_o, cyc);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_cyc  = mon_e[W-1 -: 32];
                mon_we   = mon_e[CPN+AW+FW-1 -: CPN];
                mon_addr = mon_e[AW+FW-1 -: AW];
                mon_data = mon_e[FW-1:0];
                if (int'(mon_cyc) != cyc || config_write_enable_o !== mon_we ||
                    config_addr_o !== mon_addr || config_data_o !== mon_data || ce_o !== 1'b1)
                    $display("FAIL write: got cyc=%0d we=%b addr=%h data=%h ce=%b, required cyc=%0d we=%b addr=%h data=%h ce=1",
                             cyc, config_write_enable_o, config_addr_o, config_data_o, ce_o,
                             mon_cyc, mon_we, mon_addr, mon_data);
                else
                    n_pass++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] hdr(input int t, input int base, input int n);
        return {4'(t), 16'(base), 12'(n)};
    endfunction

    // Presents one flit and returns the cycle number right after its handshake.
    task automatic send(input logic [31:0] d, output int hs_cyc);
        int waited = 0;
        @(negedge clk_i);
        flit_valid_i = 1'b1;
        flit_data_i  = d;
        #1;
        while (flit_ready_o !== 1'b1 && waited < 50) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        if (flit_ready_o !== 1'b1) begin
            n_checks++;
            $display("FAIL handshake_timeout: got ready=%b, required 1 within 50 cycles", flit_ready_o);
            hs_cyc = -1;
        end else begin
            @(posedge clk_i);
            #1;
            hs_cyc = cyc;
        end
    endtask

    task automatic send_payload(input logic [31:0] d, input int t, input int addr);
        int h;
        logic [CPN-1:0] oh;
        send(d, h);
        oh    = '0;
        oh[t] = 1'b1;
        exp_q.push_back({32'(h), oh, 16'(addr), d});
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk_i);
            flit_valid_i = 1'b0;
        end
    endtask

    // Closes a packet: drop valid during DONE, then step into IDLE.
    task automatic finish_pkt();
        idle(1);
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i        = 1'b1;
        flit_valid_i = 1'b0;
        flit_data_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (flit_ready_o !== 1'b0) $display("FAIL reset_ready: got %b required 0", flit_ready_o);
        else n_pass++;
        n_checks++;
        if ({config_data_o, config_write_enable_o, config_addr_o, ce_o, busy_o, done_o, err_o} !== '0)
            $display("FAIL reset_outputs: got data=%h we=%b addr=%h ce=%b busy=%b done=%b err=%b required all 0",
                     config_data_o, config_write_enable_o, config_addr_o, ce_o, busy_o, done_o, err_o);
        else n_pass++;
        n_checks++;
        if (state_o !== 2'd0) $display("FAIL reset_state: got %0d required 0", state_o);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (flit_ready_o !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", flit_ready_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        int h;
        send(hdr(2, 16'h0010, 3), h);
        n_checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0 || state_o !== 2'd1)
            $display("FAIL basic_header: got busy=%b err=%b state=%0d required busy=1 err=0 state=1", busy_o, err_o, state_o);
        else n_pass++;
        send_payload(32'h0000_000A, 2, 16'h0010);
        send_payload(32'h0000_000B, 2, 16'h0011);
        send_payload(32'h0000_000C, 2, 16'h0012);
        n_checks++;
        if (done_o !== 1'b1 || flit_ready_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL basic_done: got done=%b ready=%b err=%b required done=1 ready=0 err=0", done_o, flit_ready_o, err_o);
        else n_pass++;
        finish_pkt();
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL basic_idle: got done=%b busy=%b required 0 0", done_o, busy_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int h;
        send(hdr(0, 16'hFFFE, 3), h);
        send_payload($urandom, 0, 16'hFFFE);
        send_payload($urandom, 0, 16'hFFFF);
        send_payload($urandom, 0, 16'h0000);
        finish_pkt();
    endtask

    task automatic test_bad_target();
        int h;
        send(hdr(12, 16'h0000, 2), h);
        n_checks++;
        if (err_o !== 1'b1 || state_o !== 2'd2)
            $display("FAIL bad_target_header: got err=%b state=%0d required err=1 state=2", err_o, state_o);
        else n_pass++;
        send($urandom, h);
        send($urandom, h);
        n_checks++;
        if (done_o !== 1'b1 || err_o !== 1'b1)
            $display("FAIL bad_target_done: got done=%b err=%b required 1 1", done_o, err_o);
        else n_pass++;
        finish_pkt();
    endtask

    task automatic test_zero_len();
        int h;
        send(hdr(5, 16'h0030, 0), h);
        n_checks++;
        if (err_o !== 1'b0 || done_o !== 1'b1 || state_o !== 2'd3)
            $display("FAIL zero_len: got err=%b done=%b state=%0d required err=0 done=1 state=3", err_o, done_o, state_o);
        else n_pass++;
        finish_pkt();
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL zero_len_idle: got done=%b busy=%b required 0 0", done_o, busy_o);
        else n_pass++;
        send(hdr(15, 16'h0030, 0), h);
        n_checks++;
        if (err_o !== 1'b1 || done_o !== 1'b1)
            $display("FAIL bad_zero_len: got err=%b done=%b required 1 1", err_o, done_o);
        else n_pass++;
        finish_pkt();
    endtask

    task automatic test_gaps();
        int h;
        send(hdr(1, 16'h0020, 4), h);
        send_payload($urandom, 1, 16'h0020);
        idle(1);
        send_payload($urandom, 1, 16'h0021);
        send_payload($urandom, 1, 16'h0022);
        idle(1);
        send_payload($urandom, 1, 16'h0023);
        n_checks++;
        if (done_o !== 1'b1) $display("FAIL gaps_done: got %b required 1", done_o);
        else n_pass++;
        finish_pkt();
    endtask

    task automatic test_reset_mid();
        int h;
        send(hdr(1, 16'h0050, 4), h);
        send_payload($urandom, 1, 16'h0050);
        send_payload($urandom, 1, 16'h0051);
        @(negedge clk_i);
        rst_i        = 1'b1;
        flit_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || config_write_enable_o !== '0 || ce_o !== 1'b0 || state_o !== 2'd0 || flit_ready_o !== 1'b0)
            $display("FAIL reset_mid: got busy=%b we=%b ce=%b state=%0d ready=%b required 0 0 0 0 0",
                     busy_o, config_write_enable_o, ce_o, state_o, flit_ready_o);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0;
        send(hdr(3, 16'h0040, 1), h);
        n_checks++;
        if (state_o !== 2'd1 || busy_o !== 1'b1)
            $display("FAIL reset_new_header: got state=%0d busy=%b required 1 1", state_o, busy_o);
        else n_pass++;
        send_payload($urandom, 3, 16'h0040);
        finish_pkt();
    endtask

    task automatic test_stall();
        int h;
        int d0;
        send(hdr(4, 16'h0060, 2), h);
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL stall_err_clear: got %b required 0", err_o);
        else n_pass++;
        send_payload($urandom, 4, 16'h0060);
        d0 = done_cnt;
        idle(8);
        @(posedge clk_i);
        #1;
`ifdef CFG_LOADER_TIMEOUT_EN
        n_checks++;
        if (state_o !== 2'd0 || err_o !== 1'b1 || busy_o !== 1'b0 || done_cnt != d0)
            $display("FAIL timeout_abort: got state=%0d err=%b busy=%b done_pulses=%0d required 0 1 0 0",
                     state_o, err_o, busy_o, done_cnt - d0);
        else n_pass++;
`else
        n_checks++;
        if (state_o !== 2'd1 || busy_o !== 1'b1 || err_o !== 1'b0 || done_cnt != d0)
            $display("FAIL stall_wait: got state=%0d busy=%b err=%b done_pulses=%0d required 1 1 0 0",
                     state_o, busy_o, err_o, done_cnt - d0);
        else n_pass++;
        idle(12);
        send_payload($urandom, 4, 16'h0061);
        n_checks++;
        if (done_o !== 1'b1) $display("FAIL stall_done: got %b required 1", done_o);
        else n_pass++;
        finish_pkt();
`endif
    endtask

    task automatic test_back_to_back();
        int h;
        int h1;
        int h2;
        send(hdr(6, 16'h0070, 2), h);
        send_payload($urandom, 6, 16'h0070);
        send_payload($urandom, 6, 16'h0071);
        h1 = cyc;
        send(hdr(7, 16'h0080, 1), h2);
        n_checks++;
        if (h2 != h1 + 2) $display("FAIL back_to_back_gap: got %0d cycles required 2", h2 - h1);
        else n_pass++;
        send_payload($urandom, 7, 16'h0080);
        finish_pkt();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_bad_target();
        test_zero_len();
        test_gaps();
        test_reset_mid();
        test_stall();
        test_back_to_back();
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL missing_writes: got %0d pending required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
